// File: rtl/icache_pkg.sv
// Shared types and address-field positions for the instruction cache.
package icache_pkg;

  // Byte address = {tag, index, word, byte}.
  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned IDX_LSB  = 4;
  localparam int unsigned TAG_LSB  = 7;
  localparam int unsigned TAG_W    = 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    UPDATE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } line_t;

endpackage

// File: rtl/icache_data_array.sv
// Instruction data storage: one synchronous write port, one asynchronous read port.
module icache_data_array #(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned WORDS   = 4
) (
  input  logic                       clock,
  input  logic                       we_i,
  input  logic [INDEX_W-1:0]         w_idx_i,
  input  logic [$clog2(WORDS)-1:0]   w_word_i,
  input  logic [31:0]                w_data_i,
  input  logic [INDEX_W-1:0]         r_idx_i,
  input  logic [$clog2(WORDS)-1:0]   r_word_i,
  output logic [31:0]                r_data_o
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [31:0] mem_q [LINES][WORDS];

  // Refill writes one word per accepted memory beat.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[w_idx_i][w_word_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_idx_i][r_word_i];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: hit path, refill FSM, tag/valid state.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_busywait,
  input  logic              flush,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WSEL_W = $clog2(WORDS);

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;
  logic [WSEL_W-1:0]   word_cnt_q, word_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]    miss_count_q, miss_count_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [WSEL_W-1:0]   req_word;
  logic                unused_byte_sel;
  line_t               cur_line;
  logic                hit;
  logic                fill_we;
  logic                clear_all;
  logic [31:0]         rd_data;

  assign req_tag         = cpu_address[ADDR_W-1:TAG_LSB];
  assign req_idx         = cpu_address[TAG_LSB-1:IDX_LSB];
  assign req_word        = cpu_address[IDX_LSB-1:WORD_LSB];
  assign unused_byte_sel = ^cpu_address[WORD_LSB-1:0];

  assign cur_line.valid = valid_q[req_idx];
  assign cur_line.tag   = tag_q[req_idx];
  assign hit            = cur_line.valid && (cur_line.tag == req_tag);

  assign fill_we = (state_q == FETCH) && !mem_busywait;
  // A flush seen during a refill is applied on the install edge so the new line dies too.
  assign clear_all = ((state_q == IDLE) && flush) ||
                     ((state_q == UPDATE) && (flush || flush_pend_q));
  assign miss_count = miss_count_q;

  icache_data_array #(
    .INDEX_W (INDEX_W),
    .WORDS   (WORDS)
  ) u_data (
    .clock    (clock),
    .we_i     (fill_we),
    .w_idx_i  (miss_idx_q),
    .w_word_i (word_cnt_q),
    .w_data_i (mem_readdata),
    .r_idx_i  (req_idx),
    .r_word_i (req_word),
    .r_data_o (rd_data)
  );

  // Valid bits: cleared by reset or flush, set when a refill installs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (state_q == UPDATE) begin
      valid_q[miss_idx_q] <= 1'b1;
    end
  end

  // Tags are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clock) begin
    if (state_q == UPDATE) begin
      tag_q[miss_idx_q] <= miss_tag_q;
    end
  end

  // FSM and miss bookkeeping registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      word_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      word_cnt_q   <= word_cnt_d;
      flush_pend_q <= flush_pend_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    word_cnt_d   = word_cnt_q;
    flush_pend_d = flush_pend_q;
    miss_count_d = miss_count_q;
    mem_read     = 1'b0;
    mem_address  = '0;
    cpu_busywait = 1'b0;
    cpu_readdata = '0;
    unique case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        // Keep the fetch side quiet while reset is held.
        if (cpu_read && reset_n) begin
          if (hit) begin
            cpu_readdata = rd_data;
          end else begin
            cpu_busywait = 1'b1;
            miss_tag_d   = req_tag;
            miss_idx_d   = req_idx;
            word_cnt_d   = '0;
            if (miss_count_q != '1) begin
              miss_count_d = miss_count_q + 1'b1;
            end
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        mem_read     = 1'b1;
        mem_address  = {miss_tag_q, miss_idx_q, word_cnt_q, {WORD_LSB{1'b0}}};
        cpu_busywait = 1'b1;
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (!mem_busywait) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == WSEL_W'(WORDS - 1)) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        cpu_busywait = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
